// File: rtl/msg_pkg.sv
// Shared ASCII, frame-type and unit encodings for the status message transmitter and decoder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package msg_pkg;

   localparam logic [7:0] CH_F    = 8'h46;
   localparam logic [7:0] CH_I    = 8'h49;
   localparam logic [7:0] CH_M    = 8'h4D;
   localparam logic [7:0] CH_B    = 8'h42;
   localparam logic [7:0] CH_P    = 8'h50;
   localparam logic [7:0] CH_D    = 8'h44;
   localparam logic [7:0] CH_E    = 8'h45;
   localparam logic [7:0] CH_N    = 8'h4E;
   localparam logic [7:0] CH_S    = 8'h53;
   localparam logic [7:0] CH_U    = 8'h55;
   localparam logic [7:0] CH_C    = 8'h43;
   localparam logic [7:0] CH_R    = 8'h52;
   localparam logic [7:0] CH_1    = 8'h31;
   localparam logic [7:0] CH_2    = 8'h32;
   localparam logic [7:0] CH_3    = 8'h33;
   localparam logic [7:0] CH_4    = 8'h34;
   localparam logic [7:0] CH_DASH = 8'h2D;
   localparam logic [7:0] CH_HASH = 8'h23;

   typedef enum logic [1:0] {
      MSG_FIM = 2'd0,
      MSG_BPM = 2'd1,
      MSG_BDM = 2'd2,
      MSG_END = 2'd3
   } msg_type_t;

   typedef enum logic [1:0] {
      UNIT_E = 2'd0,
      UNIT_C = 2'd1,
      UNIT_R = 2'd2
   } unit_t;

   // What a frame position will accept: a literal, any unit letter, or any digit.
   typedef enum logic [1:0] {
      EXP_NONE  = 2'd0,
      EXP_LIT   = 2'd1,
      EXP_UNIT  = 2'd2,
      EXP_DIGIT = 2'd3
   } exp_cls_t;

   typedef struct packed {
      exp_cls_t   cls;
      logic [7:0] ch;
   } exp_chr_t;

   function automatic logic is_unit(input logic [7:0] b);
      return (b == CH_E) || (b == CH_C) || (b == CH_R);
   endfunction

   function automatic logic [1:0] unit_code(input logic [7:0] b);
      logic [1:0] u;
      u = UNIT_E;
      if (b == CH_C) u = UNIT_C;
      if (b == CH_R) u = UNIT_R;
      return u;
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_1) && (b <= CH_4);
   endfunction

   function automatic logic [1:0] digit_code(input logic [7:0] b);
      return b[1:0] - 2'd1;
   endfunction

endpackage

// File: rtl/msg_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles without a byte, flags the TIMEOUT_CYCLES-th one.
// Latency: expired is combinational from the count register and the current clear/enable.
// Backpressure: none; clear wins over expiry in the same cycle.
module msg_gap_timer #(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   assign expired = enable && !clear && (cnt_q == LAST);

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || !enable) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/msg_frame_decoder.sv
// Validates FIM/BPM/BDM/END ASCII frames from uart_rx and strobes decoded fields or an error.
// Latency: msg_valid / frame_error rise one cycle after the deciding byte or gap expiry.
// Backpressure: none; every rx_valid byte is consumed, bytes may arrive back-to-back.
module msg_frame_decoder #(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int MAX_LEN        = 13
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       msg_valid,
   output logic [1:0] msg_type,
   output logic [1:0] unit_id,
   output logic [1:0] su_id,
   output logic [1:0] block_id,
   output logic       frame_error
);

   import msg_pkg::*;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECV    = 2'd1,
      S_DISCARD = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(MAX_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   msg_type_t  typ_q, typ_d;
   logic [1:0] cap_unit_q, cap_unit_d;
   logic [1:0] cap_su_q, cap_su_d;
   logic [1:0] cap_blk_q, cap_blk_d;
   logic       msg_vld_d, err_d;
   logic       gap_en, gap_expired;
   exp_chr_t   exp_c;
   logic       hit, to_bdm, is_term;

   function automatic exp_chr_t lit(input logic [7:0] c);
      return '{cls: EXP_LIT, ch: c};
   endfunction

   function automatic exp_chr_t wild(input exp_cls_t c);
      return '{cls: c, ch: 8'h00};
   endfunction

   // Expected character per (type, position); BPM stands in for both B frames until idx 1.
   function automatic exp_chr_t exp_chr(input msg_type_t t, input logic [3:0] i);
      exp_chr_t e;
      e = wild(EXP_NONE);
      case (t)
         MSG_FIM: case (i)
            4'd0: e = lit(CH_F);        4'd1: e = lit(CH_I);
            4'd2: e = lit(CH_M);        4'd3: e = lit(CH_DASH);
            4'd4: e = wild(EXP_UNIT);   4'd5: e = lit(CH_S);
            4'd6: e = lit(CH_U);        4'd7: e = wild(EXP_DIGIT);
            4'd8: e = lit(CH_DASH);     4'd9: e = lit(CH_HASH);
            default: e = wild(EXP_NONE);
         endcase
         MSG_BPM: case (i)
            4'd0: e = lit(CH_B);        4'd1: e = lit(CH_P);
            4'd2: e = lit(CH_M);        4'd3: e = lit(CH_DASH);
            4'd4: e = lit(CH_S);        4'd5: e = lit(CH_U);
            4'd6: e = lit(CH_DASH);     4'd7: e = lit(CH_B);
            4'd8: e = wild(EXP_DIGIT);  4'd9: e = lit(CH_DASH);
            4'd10: e = lit(CH_HASH);
            default: e = wild(EXP_NONE);
         endcase
         MSG_BDM: case (i)
            4'd0: e = lit(CH_B);        4'd1: e = lit(CH_D);
            4'd2: e = lit(CH_M);        4'd3: e = lit(CH_DASH);
            4'd4: e = wild(EXP_UNIT);   4'd5: e = lit(CH_S);
            4'd6: e = lit(CH_U);        4'd7: e = wild(EXP_DIGIT);
            4'd8: e = lit(CH_DASH);     4'd9: e = lit(CH_B);
            4'd10: e = wild(EXP_DIGIT); 4'd11: e = lit(CH_DASH);
            4'd12: e = lit(CH_HASH);
            default: e = wild(EXP_NONE);
         endcase
         default: case (i)
            4'd0: e = lit(CH_E);        4'd1: e = lit(CH_N);
            4'd2: e = lit(CH_D);        4'd3: e = lit(CH_DASH);
            4'd4: e = lit(CH_HASH);
            default: e = wild(EXP_NONE);
         endcase
      endcase
      return e;
   endfunction

   assign gap_en = (state_q == S_RECV) || (state_q == S_DISCARD);

   msg_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .enable  (gap_en),
      .expired (gap_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      typ_d      = typ_q;
      cap_unit_d = cap_unit_q;
      cap_su_d   = cap_su_q;
      cap_blk_d  = cap_blk_q;
      msg_vld_d  = 1'b0;
      err_d      = 1'b0;
      hit        = 1'b0;

      exp_c   = exp_chr(typ_q, idx_q);
      to_bdm  = (typ_q == MSG_BPM) && (idx_q == 4'd1) && (rx_data == CH_D);
      is_term = (exp_c.cls == EXP_LIT) && (exp_c.ch == CH_HASH);
      case (exp_c.cls)
         EXP_LIT:   hit = (rx_data == exp_c.ch);
         EXP_UNIT:  hit = is_unit(rx_data);
         EXP_DIGIT: hit = is_digit(rx_data);
         default:   hit = 1'b0;
      endcase
      hit = (hit || to_bdm) && (idx_q <= LAST_IDX);

      case (state_q)
         // DONE only exists to show the strobe; incoming bytes are handled as in IDLE.
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            if (rx_valid && ((rx_data == CH_F) || (rx_data == CH_B) || (rx_data == CH_E))) begin
               state_d    = S_RECV;
               idx_d      = 4'd1;
               cap_unit_d = 2'd0;
               cap_su_d   = 2'd0;
               cap_blk_d  = 2'd0;
               typ_d      = (rx_data == CH_F) ? MSG_FIM :
                            (rx_data == CH_B) ? MSG_BPM : MSG_END;
            end
         end
         S_RECV: begin
            if (rx_valid) begin
               if (hit && is_term) begin
                  state_d   = S_DONE;
                  msg_vld_d = 1'b1;
               end else if (hit) begin
                  idx_d = idx_q + 4'd1;
                  if (to_bdm) typ_d = MSG_BDM;
                  if (exp_c.cls == EXP_UNIT) cap_unit_d = unit_code(rx_data);
                  if (exp_c.cls == EXP_DIGIT) begin
                     if (idx_q == 4'd7) cap_su_d = digit_code(rx_data);
                     else               cap_blk_d = digit_code(rx_data);
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = (rx_data == CH_HASH) ? S_IDLE : S_DISCARD;
               end
            end else if (gap_expired) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (rx_valid) begin
               if (rx_data == CH_HASH) state_d = S_IDLE;
            end else if (gap_expired) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= 4'd0;
         typ_q       <= MSG_FIM;
         cap_unit_q  <= 2'd0;
         cap_su_q    <= 2'd0;
         cap_blk_q   <= 2'd0;
         msg_valid   <= 1'b0;
         frame_error <= 1'b0;
         msg_type    <= 2'd0;
         unit_id     <= 2'd0;
         su_id       <= 2'd0;
         block_id    <= 2'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         typ_q       <= typ_d;
         cap_unit_q  <= cap_unit_d;
         cap_su_q    <= cap_su_d;
         cap_blk_q   <= cap_blk_d;
         msg_valid   <= msg_vld_d;
         frame_error <= err_d;
         if (msg_vld_d) begin
            msg_type <= typ_q;
            unit_id  <= cap_unit_q;
            su_id    <= cap_su_q;
            block_id <= cap_blk_q;
         end
      end
   end

endmodule

// File: tb/tb_msg_frame_decoder.sv
// Self-checking bench for msg_frame_decoder: frame table, hand-written corner sequences, random traffic.
// A template-matching reference model predicts every cycle's outputs.
module tb_msg_frame_decoder;

   localparam int TMO = 100;

   logic       clk_50M = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       msg_valid;
   logic [1:0] msg_type;
   logic [1:0] unit_id;
   logic [1:0] su_id;
   logic [1:0] block_id;
   logic       frame_error;

   msg_frame_decoder #(
      .TIMEOUT_CYCLES(TMO),
      .MAX_LEN(13)
   ) dut (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .msg_valid   (msg_valid),
      .msg_type    (msg_type),
      .unit_id     (unit_id),
      .su_id       (su_id),
      .block_id    (block_id),
      .frame_error (frame_error)
   );

   always #10 clk_50M = ~clk_50M;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_pulse = 0;
   int n_err = 0;

   logic [9:0] obs;
   assign obs = {msg_valid, msg_type, unit_id, su_id, block_id, frame_error};

   // Reference model: '?' = unit letter, 'n' = SU digit, 'm' = block digit; index = msg_type.
   string tmpl [4] = '{"FIM-?SUn-#", "BPM-SU-Bm-#", "BDM-?SUn-Bm-#", "END-#"};
   logic [7:0] units [3] = '{8'h45, 8'h43, 8'h52};
   logic [7:0] junk  [7] = '{8'h2D, 8'h23, 8'h58, 8'h31, 8'h45, 8'h42, 8'h53};
   int         m_mode;   // 0 hunting, 1 inside a frame, 2 discarding
   int         m_gap;
   logic [7:0] fbuf [$];
   logic       e_mv, e_fe;
   logic [1:0] e_typ, e_unit, e_su, e_blk;

   function automatic bit char_ok(input logic [7:0] t, input logic [7:0] b);
      if (t == 8'h3F) return (b == 8'h45) || (b == 8'h43) || (b == 8'h52);
      if (t == 8'h6E || t == 8'h6D) return (b >= 8'h31) && (b <= 8'h34);
      return t == b;
   endfunction

   function automatic bit is_prefix(input int k);
      if (fbuf.size() > tmpl[k].len()) return 1'b0;
      for (int i = 0; i < fbuf.size(); i++)
         if (!char_ok(tmpl[k][i], fbuf[i])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_gap = 0; fbuf.delete();
      e_mv = 0; e_fe = 0; e_typ = 0; e_unit = 0; e_su = 0; e_blk = 0;
   endfunction

   function automatic void model_step(input bit v, input logic [7:0] d);
      int done;
      bit any;
      e_mv = 0;
      e_fe = 0;
      if (v) begin
         m_gap = 0;
         if (m_mode == 0) begin
            if (d == 8'h46 || d == 8'h42 || d == 8'h45) begin
               fbuf.delete();
               fbuf.push_back(d);
               m_mode = 1;
            end
         end else if (m_mode == 1) begin
            fbuf.push_back(d);
            any = 0;
            done = -1;
            for (int k = 0; k < 4; k++) begin
               if (is_prefix(k)) begin
                  any = 1;
                  if (fbuf.size() == tmpl[k].len()) done = k;
               end
            end
            if (done >= 0) begin
               e_mv = 1; e_typ = 2'(done); e_unit = 0; e_su = 0; e_blk = 0;
               for (int i = 0; i < fbuf.size(); i++) begin
                  if (tmpl[done][i] == 8'h3F)
                     e_unit = (fbuf[i] == 8'h45) ? 2'd0 : (fbuf[i] == 8'h43) ? 2'd1 : 2'd2;
                  if (tmpl[done][i] == 8'h6E) e_su  = 2'(fbuf[i] - 8'h31);
                  if (tmpl[done][i] == 8'h6D) e_blk = 2'(fbuf[i] - 8'h31);
               end
               m_mode = 0;
            end else if (!any) begin
               e_fe = 1;
               m_mode = (d == 8'h23) ? 0 : 2;
            end
         end else begin
            if (d == 8'h23) m_mode = 0;
         end
      end else if (m_mode != 0) begin
         m_gap++;
         if (m_gap == TMO) begin
            if (m_mode == 1) e_fe = 1;
            m_mode = 0;
         end
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = v ? d : 8'h00;
      @(posedge clk_50M);
      model_step(v, d);
      @(negedge clk_50M);
      cyc++;
      chk("cycle_outputs", int'(obs), int'({e_mv, e_typ, e_unit, e_su, e_blk, e_fe}));
      if (msg_valid)   n_pulse++;
      if (frame_error) n_err++;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
   endtask

   typedef struct {
      string s;
      int    pulses;
      int    errs;
      int    typ;
      int    unit;
      int    su;
      int    blk;
   } vec_t;

   vec_t       tv [12];
   int         k, g, cut;
   logic [7:0] c;
   logic [7:0] q [$];

   initial begin
      tv[0]  = '{"FIM-RSU3-#",      1, 0, 0, 2, 2, 0};
      tv[1]  = '{"BDM-CSU1-B4-#",   1, 0, 2, 1, 0, 3};
      tv[2]  = '{"BPM-SU-B2-#",     1, 0, 1, 0, 0, 1};
      tv[3]  = '{"FIM-XSU1-#",      0, 1, 1, 0, 0, 1};
      tv[4]  = '{"END-#",           1, 0, 3, 0, 0, 0};
      tv[5]  = '{"BPM-S#",          0, 1, 3, 0, 0, 0};
      tv[6]  = '{"FIM-ESU4-#",      1, 0, 0, 0, 3, 0};
      tv[7]  = '{"BDM-ESU2-B1-#",   1, 0, 2, 0, 1, 0};
      tv[8]  = '{"xyzEND-#",        1, 0, 3, 0, 0, 0};
      tv[9]  = '{"BDM-RSU4-B3-##",  1, 0, 2, 2, 3, 2};
      tv[10] = '{"BXM-#",           0, 1, 2, 2, 3, 2};
      tv[11] = '{"FIM-CSU1-B-#",    0, 1, 2, 2, 3, 2};

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      model_reset();
      repeat (3) @(negedge clk_50M);
      chk("reset_state", int'(obs), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         n_pulse = 0; n_err = 0;
         send_str(tv[i].s);
         repeat (3) step(1'b0, 8'h00);
         chk($sformatf("tv%0d_counts", i), n_pulse * 16 + n_err, tv[i].pulses * 16 + tv[i].errs);
         chk($sformatf("tv%0d_fields", i), int'({msg_type, unit_id, su_id, block_id}),
             tv[i].typ * 64 + tv[i].unit * 16 + tv[i].su * 4 + tv[i].blk);
      end

      // Gap expiry inside a frame: one error, exactly on the TMO-th idle cycle.
      n_err = 0;
      send_str("FIM-E");
      repeat (TMO - 1) step(1'b0, 8'h00);
      chk("tmo_not_early", n_err, 0);
      step(1'b0, 8'h00);
      chk("tmo_fires", int'(frame_error), 1);
      repeat (20) step(1'b0, 8'h00);
      chk("tmo_single", n_err, 1);

      // A byte landing on the expiry cycle keeps the frame alive.
      n_err = 0; n_pulse = 0;
      send_str("FIM-E");
      repeat (TMO - 1) step(1'b0, 8'h00);
      step(1'b1, 8'h53);
      send_str("U1-#");
      step(1'b0, 8'h00);
      chk("tmo_byte_wins", n_pulse * 16 + n_err, 16);
      chk("tmo_byte_fields", int'({msg_type, unit_id, su_id, block_id}), 0);

      // Gap expiry while discarding gives no second error.
      n_err = 0;
      send_str("FIM-X");
      repeat (TMO + 30) step(1'b0, 8'h00);
      chk("discard_tmo", n_err, 1);
      send_str("END-#");
      step(1'b0, 8'h00);
      chk("after_discard_end", int'(msg_type), 3);

      // Reset in the middle of a frame clears everything.
      send_str("BDM-CSU1-B4-#");
      send_str("BDM-E");
      rx_valid = 1'b0;
      #3 rst_n = 1'b0;
      #2 chk("reset_mid_frame", int'(obs), 0);
      model_reset();
      @(negedge clk_50M);
      chk("reset_held", int'(obs), 0);
      rst_n = 1'b1;
      n_pulse = 0; n_err = 0;
      send_str("END-#");
      step(1'b0, 8'h00);
      chk("post_reset_end", n_pulse * 256 + n_err * 16 + int'(msg_type), 256 + 3);

      // Random traffic: legal, corrupted and truncated frames with mixed gaps and noise.
      for (int f = 0; f < 150; f++) begin
         k = $urandom_range(0, 3);
         q.delete();
         for (int i = 0; i < tmpl[k].len(); i++) begin
            c = tmpl[k][i];
            if (c == 8'h3F) c = units[$urandom_range(0, 2)];
            else if (c == 8'h6E || c == 8'h6D) c = 8'h31 + 8'($urandom_range(0, 3));
            q.push_back(c);
         end
         if ($urandom_range(0, 4) == 0) q[$urandom_range(0, q.size() - 1)] = junk[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) begin
            cut = $urandom_range(1, q.size());
            while (q.size() > cut) void'(q.pop_back());
         end
         for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            g = ($urandom_range(0, 39) == 0) ? $urandom_range(TMO - 5, TMO + 5) : $urandom_range(0, 2);
            repeat (g) step(1'b0, 8'h00);
         end
         if ($urandom_range(0, 5) == 0) step(1'b1, junk[$urandom_range(0, 6)]);
      end
      repeat (TMO + 5) step(1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msg_frame_decoder.md
# msg_frame_decoder

Receive-side counterpart of the status message transmitter: accepts a byte stream from the UART receiver, validates ASCII frames of the form `FIM-ESU3-#`, `BPM-SU-B2-#`, `BDM-CSU1-B4-#` and `END-#`, and emits the decoded fields with a one-cycle strobe. It sits between `uart_rx` and the bot control FSM, and in test fixtures it checks transmitter output end-to-end. Malformed, truncated or stalled frames are rejected with an error strobe, and the decoder resynchronises on the next frame.

## Interface
- `TIMEOUT_CYCLES`, default 50000000: maximum idle cycles between bytes inside a frame (1 s at 50 MHz).
- `MAX_LEN`, default 13: longest legal frame in bytes, terminator included.

- `clk_50M`  in  1  system clock, 50 MHz; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `msg_valid`  out  1  one-cycle pulse: a complete legal frame has been decoded.
- `msg_type`  out  2  frame type: 0 FIM (fault), 1 BPM (pickup), 2 BDM (deposit), 3 END.
- `unit_id`  out  2  unit letter: E=0, C=1, R=2. Reads 0 for BPM and END.
- `su_id`  out  2  SU digit '1'..'4' mapped to 0..3. Reads 0 for BPM and END.
- `block_id`  out  2  block digit '1'..'4' mapped to 0..3. Reads 0 for FIM and END.
- `frame_error`  out  1  one-cycle pulse: a frame was rejected.

## Operation
- Grammar, position by position, where U is in {E,C,R}, n and m are in '1'..'4', '-' is 0x2D and '#' is 0x23:
  - FIM-UnSUn… exactly: `F I M - U S U n - #` (10 bytes).
  - BPM: `B P M - S U - B m - #` (11 bytes).
  - BDM: `B D M - U S U n - B m - #` (13 bytes).
  - END: `E N D - #` (5 bytes).
- FSM states:
  - IDLE
    - On `rx_valid`, byte 'F', 'B' or 'E' → RECV with `idx`=1. All other bytes are ignored silently, with no error.
  - RECV
    - Each `rx_valid` byte is checked against the expected character for (`type`, `idx`).
    - The type is resolved at idx 0 for F and E, and at idx 1 for B (byte 'P' or 'D').
    - Match and not the terminator: capture the field if applicable; `idx`++.
    - Match on the terminator: → DONE.
    - Mismatch where the byte is not '#': pulse `frame_error`; → DISCARD.
    - Mismatch where the byte is '#': pulse `frame_error`; → IDLE (immediate resync).
  - DISCARD
    - Drop bytes until '#'; then → IDLE.
    - The gap timeout also applies here: → IDLE with no second error pulse.
  - DONE
    - Load the output field registers from the capture registers; pulse `msg_valid`; → IDLE on the next cycle.
    - A byte arriving in the DONE cycle is processed as if in IDLE.
- Gap timer: counts cycles in RECV and DISCARD, and clears on every `rx_valid`.
  - Reaching `TIMEOUT_CYCLES` in RECV: pulse `frame_error`; → IDLE.
  - If `rx_valid` and expiry coincide, the byte wins: the timer clears and the byte is processed.
- `idx` is 4 bits. It can never exceed `MAX_LEN`-1, because a mismatch fires first.
- Output fields are held until the next `msg_valid`. Errors do not alter them.

## Timing
- Reset (async assert, synchronous release): FSM=IDLE, `idx`=0, timer=0. All outputs and capture registers are 0.
- Latency: `msg_valid` is high exactly 1 cycle after the cycle in which the '#' `rx_valid` is sampled. Fields are valid in the same cycle as `msg_valid`.
- `frame_error`: high the cycle after the offending byte or the timeout. It is never asserted together with `msg_valid`.
- Bytes may arrive back-to-back, with `rx_valid` high on consecutive cycles. No backpressure exists, so every strobed byte is consumed.
- `rst_n` low mid-frame: the partial frame is discarded, with no `msg_valid` and no `frame_error`.

## Structure
- Shared package `msg_pkg`, also used by the transmitter, holds:
  - ASCII constants (F, I, M, B, P, D, E, N, S, U, C, R, digits '1'..'4', DASH, HASH).
  - `msg_type` encodings.
  - The unit encoding.
- Sub-module `msg_gap_timer` contains the inter-byte timeout counter, with `clear`, `enable` and `expired` signals, parameterised by `TIMEOUT_CYCLES`.
- The expected-character lookup is a combinational function of (`type`, `idx`) in the main module.

## Test plan
- Legal FIM: send "FIM-RSU3-#" back-to-back → one `msg_valid`, 1 cycle after '#'. Expect `msg_type`=0, `unit_id`=2, `su_id`=2, `block_id`=0.
- Legal BDM, then BPM, with 10-cycle gaps: "BDM-CSU1-B4-#" then "BPM-SU-B2-#". The first pulse gives type 2 / unit 1 / su 0 / block 3; the second gives type 1 / block 1.
- Corruption: send "FIM-XSU1-#" → `frame_error` 1 cycle after 'X', no `msg_valid`. A following "END-#" decodes as type 3.
- Early terminator: send "BPM-S#", then "END-#" → `frame_error` on '#', the decoder returns to IDLE, and END decodes correctly.
- Timeout: with `TIMEOUT_CYCLES`=100, send "FIM-E" then idle 100 cycles → a single `frame_error`. A byte landing exactly on cycle 100 prevents the error.
- Reset mid-frame: assert `rst_n` low after "BDM-E" → all outputs are 0. No pulses appear, and a new "END-#" decodes normally.
